// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - memory read handshake and instruction-register handshake bundle
interface fetch_unit_if #(
  parameter int WIDTH = 16
);
  logic             mem_req;
  logic [WIDTH-1:0] mem_addr;
  logic             mem_ack;
  logic [WIDTH-1:0] mem_rdata;
  logic [WIDTH-1:0] instr;
  logic [WIDTH-1:0] instr_pc;
  logic             instr_valid;
  logic             instr_ready;

  modport master (
    output mem_req, mem_addr, instr, instr_pc, instr_valid,
    input  mem_ack, mem_rdata, instr_ready
  );

  modport slave (
    input  mem_req, mem_addr, instr, instr_pc, instr_valid,
    output mem_ack, mem_rdata, instr_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC owner with req/ack instruction fetch, redirect/squash and accepted-word counter
module fetch_unit #(
  parameter int               WIDTH        = 16,
  parameter int               PC_STEP      = 1,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int               CNT_W        = 16
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_fetch_en,
  input  logic             i_redirect_en,
  input  logic [WIDTH-1:0] i_redirect_addr,
  fetch_unit_if.master     bus,
  output logic [WIDTH-1:0] o_pc,
  output logic [CNT_W-1:0] o_fetch_count
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] REQ   = 2'd1;
  localparam logic [1:0] VALID = 2'd2;

  localparam logic [WIDTH-1:0] STEP = WIDTH'(PC_STEP);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_pc;
  logic             r_squash;
  logic [CNT_W-1:0] r_count;
  logic             r_mem_req;
  logic [WIDTH-1:0] r_mem_addr;
  logic [WIDTH-1:0] r_instr;
  logic [WIDTH-1:0] r_instr_pc;
  logic             r_instr_valid;

  logic [WIDTH-1:0] w_next_pc;
  logic             w_accept;
  logic             w_count_max;

  // A redirect always wins over the sequential PC for whatever fetch starts next.
  assign w_next_pc   = i_redirect_en ? i_redirect_addr : r_pc;
  assign w_accept    = (r_state == VALID) && r_instr_valid && bus.instr_ready;
  assign w_count_max = &r_count;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state       <= IDLE;
      r_pc          <= RESET_VECTOR;
      r_squash      <= 1'b0;
      r_count       <= '0;
      r_mem_req     <= 1'b0;
      r_mem_addr    <= RESET_VECTOR;
      r_instr       <= '0;
      r_instr_pc    <= '0;
      r_instr_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_pc <= w_next_pc;
          if (i_fetch_en) begin
            r_state    <= REQ;
            r_mem_req  <= 1'b1;
            r_mem_addr <= w_next_pc;
          end
        end
        REQ: begin
          if (bus.mem_ack) begin
            if (!r_squash && !i_redirect_en) begin
              r_instr       <= bus.mem_rdata;
              r_instr_pc    <= r_mem_addr;
              r_instr_valid <= 1'b1;
              r_pc          <= r_pc + STEP;
              r_mem_req     <= 1'b0;
              r_state       <= VALID;
            end else begin
              // Stale data: drop it and, if still fetching, re-request at the new PC.
              r_squash <= 1'b0;
              r_pc     <= w_next_pc;
              if (i_fetch_en) begin
                r_mem_addr <= w_next_pc;
              end else begin
                r_mem_req <= 1'b0;
                r_state   <= IDLE;
              end
            end
          end else if (i_redirect_en) begin
            r_pc     <= i_redirect_addr;
            r_squash <= 1'b1;
          end
        end
        VALID: begin
          if (w_accept && !w_count_max) begin
            r_count <= r_count + 1'b1;
          end
          if (w_accept || i_redirect_en) begin
            r_instr_valid <= 1'b0;
            r_pc          <= w_next_pc;
            if (i_fetch_en) begin
              r_state    <= REQ;
              r_mem_req  <= 1'b1;
              r_mem_addr <= w_next_pc;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: begin
          r_state       <= IDLE;
          r_mem_req     <= 1'b0;
          r_instr_valid <= 1'b0;
          r_squash      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_req     = r_mem_req;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.instr       = r_instr;
  assign bus.instr_pc    = r_instr_pc;
  assign bus.instr_valid = r_instr_valid;
  assign o_pc            = r_pc;
  assign o_fetch_count   = r_count;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed-vector bench for fetch_unit
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        fetch_en = 1'b0;
  logic        redirect_en = 1'b0;
  logic [15:0] redirect_addr = 16'h0;
  logic [15:0] pc;
  logic [15:0] fetch_count;

  logic        fetch_en8 = 1'b0;
  logic        redirect_en8 = 1'b0;
  logic [7:0]  redirect_addr8 = 8'h0;
  logic [7:0]  pc8;
  logic [1:0]  fetch_count8;

  int n_checks = 0;
  int n_errors = 0;
  int lat = 0;
  int wait_cnt = 0;
  int wait_cnt8 = 0;
  logic [15:0] q_ack_addr[$];
  logic [7:0]  q8_addr[$];

  fetch_unit_if #(.WIDTH(16)) mif ();
  fetch_unit_if #(.WIDTH(8))  mif8 ();

  fetch_unit #(.WIDTH(16), .PC_STEP(1), .RESET_VECTOR(16'h0000), .CNT_W(16)) u_dut (
    .i_clock(clock), .i_reset_n(reset_n), .i_fetch_en(fetch_en),
    .i_redirect_en(redirect_en), .i_redirect_addr(redirect_addr),
    .bus(mif), .o_pc(pc), .o_fetch_count(fetch_count)
  );

  fetch_unit #(.WIDTH(8), .PC_STEP(1), .RESET_VECTOR(8'hFE), .CNT_W(2)) u_dut8 (
    .i_clock(clock), .i_reset_n(reset_n), .i_fetch_en(fetch_en8),
    .i_redirect_en(redirect_en8), .i_redirect_addr(redirect_addr8),
    .bus(mif8), .o_pc(pc8), .o_fetch_count(fetch_count8)
  );

  initial forever #5 clock = ~clock;

  initial begin
    mif.mem_ack = 1'b0;  mif.mem_rdata = '0;  mif.instr_ready = 1'b0;
    mif8.mem_ack = 1'b0; mif8.mem_rdata = '0; mif8.instr_ready = 1'b0;
  end

  // Memory models update on the falling edge; ack is a one-cycle pulse after lat wait cycles.
  always @(negedge clock) begin
    if (!reset_n) begin
      mif.mem_ack = 1'b0;
      wait_cnt = 0;
    end else if (mif.mem_ack) begin
      mif.mem_ack = 1'b0;
    end else if (mif.mem_req) begin
      if (wait_cnt == lat) begin
        mif.mem_ack = 1'b1;
        mif.mem_rdata = mif.mem_addr + 16'd100;
        q_ack_addr.push_back(mif.mem_addr);
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end
  end

  always @(negedge clock) begin
    if (!reset_n) begin
      mif8.mem_ack = 1'b0;
      wait_cnt8 = 0;
    end else if (mif8.mem_ack) begin
      mif8.mem_ack = 1'b0;
    end else if (mif8.mem_req) begin
      mif8.mem_ack = 1'b1;
      mif8.mem_rdata = mif8.mem_addr + 8'd100;
      q8_addr.push_back(mif8.mem_addr);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int n;
    logic stable;
    logic [15:0] a0;

    repeat (3) tick();
    check("rst_mem_req", mif.mem_req, 0);
    check("rst_mem_addr", mif.mem_addr, 16'h0);
    check("rst_pc", pc, 16'h0);
    check("rst_instr", {mif.instr, mif.instr_pc}, 32'h0);
    check("rst_valid", mif.instr_valid, 0);
    check("rst_count", fetch_count, 0);
    check("rst_pc8", pc8, 8'hFE);
    check("rst_mem_addr8", mif8.mem_addr, 8'hFE);
    reset_n = 1'b1;

    // 1: back-to-back fetch with 1-cycle ack
    lat = 0; fetch_en = 1'b1; mif.instr_ready = 1'b1;
    for (int i = 0; i < 60 && fetch_count != 16'd3; i++) tick();
    check("t1_timeout", fetch_count == 16'd3, 1);
    check("t1_pc", pc, 16'd3);
    check("t1_req_next", {mif.mem_req, mif.mem_addr}, {1'b1, 16'd3});
    check("t1_addr0", q_ack_addr[0], 16'd0);
    check("t1_addr1", q_ack_addr[1], 16'd1);
    check("t1_addr2", q_ack_addr[2], 16'd2);
    fetch_en = 1'b0;
    for (int i = 0; i < 20 && (mif.mem_req || mif.instr_valid); i++) begin
      if (mif.instr_valid) check("t1_instr3", {mif.instr, mif.instr_pc}, {16'd103, 16'd3});
      tick();
    end
    check("t1_count_end", fetch_count, 16'd4);
    check("t1_pc_end", pc, 16'd4);

    // 2: slow memory, request held and address frozen until ack
    lat = 4; fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    check("t2_req_rise", mif.mem_req, 1);
    a0 = mif.mem_addr; stable = 1'b1; n = 0;
    while (mif.mem_req && n < 20) begin
      if (mif.mem_addr != a0) stable = 1'b0;
      n++;
      tick();
    end
    check("t2_req_cycles", n, 5);
    check("t2_addr_stable", {stable, a0}, {1'b1, 16'd4});
    check("t2_valid_after_ack", mif.instr_valid, 1);
    check("t2_instr", {mif.instr, mif.instr_pc}, {16'd104, 16'd4});
    tick();
    check("t2_count", {fetch_count, pc}, {16'd5, 16'd5});

    // 3: consumer stalls for 5 cycles
    lat = 0; mif.instr_ready = 1'b0; fetch_en = 1'b1;
    for (int i = 0; i < 20 && !mif.instr_valid; i++) tick();
    check("t3_timeout", mif.instr_valid, 1);
    for (int i = 0; i < 5; i++) begin
      check("t3_hold", {mif.instr_valid, mif.mem_req, mif.instr, mif.instr_pc}, {1'b1, 1'b0, 16'd105, 16'd5});
      tick();
    end
    check("t3_count_stalled", fetch_count, 16'd5);
    lat = 4; mif.instr_ready = 1'b1;
    tick();
    check("t3_count_once", fetch_count, 16'd6);

    // 4: redirect while the request at 6 is outstanding
    check("t4_req", {mif.mem_req, mif.mem_addr}, {1'b1, 16'd6});
    redirect_en = 1'b1; redirect_addr = 16'h0040;
    tick();
    redirect_en = 1'b0;
    check("t4_pc_redirect", pc, 16'h0040);
    check("t4_req_frozen", {mif.mem_req, mif.mem_addr}, {1'b1, 16'd6});
    for (int i = 0; i < 40 && !mif.instr_valid; i++) tick();
    fetch_en = 1'b0;
    check("t4_instr", {mif.instr, mif.instr_pc}, {16'h00A4, 16'h0040});
    check("t4_count_drop", fetch_count, 16'd6);
    check("t4_ack_seq", {q_ack_addr[q_ack_addr.size()-2], q_ack_addr[q_ack_addr.size()-1]}, {16'd6, 16'h0040});
    tick();
    check("t4_count_after", {fetch_count, pc}, {16'd7, 16'h0041});
    tick();

    // idle redirect only moves the PC
    redirect_en = 1'b1; redirect_addr = 16'h0010;
    tick();
    redirect_en = 1'b0;
    check("idle_redirect", {mif.mem_req, pc}, {1'b0, 16'h0010});

    // 5: 8-bit wrap and 2-bit saturating counter
    fetch_en8 = 1'b1; mif8.instr_ready = 1'b1;
    for (int i = 0; i < 60 && q8_addr.size() < 5; i++) tick();
    fetch_en8 = 1'b0;
    repeat (6) tick();
    check("t5_addr0", q8_addr[0], 8'hFE);
    check("t5_addr1", q8_addr[1], 8'hFF);
    check("t5_addr2", q8_addr[2], 8'h00);
    check("t5_count_sat", fetch_count8, 2'd3);

    // 6: reset during an outstanding request
    lat = 4; fetch_en = 1'b1;
    for (int i = 0; i < 20 && !mif.mem_req; i++) tick();
    tick();
    reset_n = 1'b0;
    #1;
    check("t6_req", {mif.mem_req, mif.instr_valid}, 0);
    check("t6_addr_pc", {mif.mem_addr, pc}, 32'h0);
    check("t6_instr", {mif.instr, mif.instr_pc}, 32'h0);
    check("t6_count", fetch_count, 0);
    check("t6_dut8", {pc8, 6'd0, fetch_count8}, {8'hFE, 8'h00});
    lat = 0;
    repeat (2) tick();
    q_ack_addr.delete();
    reset_n = 1'b1;
    for (int i = 0; i < 20 && q_ack_addr.size() == 0; i++) tick();
    check("t6_restart_addr", q_ack_addr.size() > 0 ? q_ack_addr[0] : 16'hFFFF, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
